// File: rtl/labmininios_cpu_debug_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : labmininios_cpu_debug_pkg
// Description : Shared types and constants for the Nios II debug host.
// Revision    : 1.0 - initial release
// ============================================================================
package labmininios_cpu_debug_pkg;

    localparam int IR_WIDTH_DEFAULT = 2;
    localparam int DR_WIDTH_DEFAULT = 38;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_UIR  = 3'd1;
    localparam logic [2:0] ST_CDR  = 3'd2;
    localparam logic [2:0] ST_SDR  = 3'd3;
    localparam logic [2:0] ST_UDR  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_UIR  = ST_UIR,
        S_CDR  = ST_CDR,
        S_SDR  = ST_SDR,
        S_UDR  = ST_UDR,
        S_DONE = ST_DONE
    } host_state_e;

    // Virtual IR codes understood by the debug slave.
    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    // Counter width that stays at least one bit for a terminal count of 0.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/labmininios_cpu_debug_host_if.sv
`default_nettype none
// ============================================================================
// Module      : labmininios_cpu_debug_host_if
// Description : Command / response handshake bundle of the debug host.
// Revision    : 1.0 - initial release
// ============================================================================
interface labmininios_cpu_debug_host_if
    import labmininios_cpu_debug_pkg::*;
#(
    parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                cmd_ir_only;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr
    );
endinterface
`default_nettype wire

// File: rtl/labmininios_cpu_debug_host_shifter.sv
`default_nettype none
// ============================================================================
// Module      : labmininios_cpu_debug_host_shifter
// Description : Bit-period divider, bit counter, DR shift and tdo capture.
// Revision    : 1.0 - initial release
// ============================================================================
module labmininios_cpu_debug_host_shifter
    import labmininios_cpu_debug_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int TCK_DIV  = 2
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                load_i,
    input  wire logic                start_i,
    input  wire logic [DR_WIDTH-1:0] data_i,
    input  wire logic                tdo_i,
    output logic                     tck_o,
    output logic                     tdi_o,
    output logic                     done_o,
    output logic [DR_WIDTH-1:0]      capture_o
);
    localparam int DIV_W = cnt_width(TCK_DIV);
    localparam int BIT_W = cnt_width(DR_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    logic                active_q;
    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic [DR_WIDTH-1:0] sr_q;
    logic [DR_WIDTH-1:0] cap_q;

    assign tck_o     = active_q && (div_q == DIV_LAST);
    assign done_o    = tck_o && (bit_q == BIT_LAST);
    assign tdi_o     = active_q & sr_q[0];
    assign capture_o = cap_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            cap_q    <= '0;
        end else begin
            if (load_i) begin
                sr_q  <= data_i;
                cap_q <= '0;
            end
            if (start_i) begin
                active_q <= 1'b1;
                div_q    <= '0;
                bit_q    <= '0;
            end else if (tck_o) begin
                // tdo enters at the MSB so the first bit ends up at bit 0.
                cap_q <= {tdo_i, cap_q[DR_WIDTH-1:1]};
                sr_q  <= {1'b0, sr_q[DR_WIDTH-1:1]};
                div_q <= '0;
                if (done_o) begin
                    active_q <= 1'b0;
                    bit_q    <= '0;
                end else begin
                    bit_q <= bit_q + BIT_W'(1);
                end
            end else if (active_q) begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/labmininios_cpu_debug_host.sv
`default_nettype none
// ============================================================================
// Module      : labmininios_cpu_debug_host
// Description : Virtual-JTAG initiator driving the Nios II debug slave.
// Revision    : 1.0 - initial release
// ============================================================================
module labmininios_cpu_debug_host
    import labmininios_cpu_debug_pkg::*;
#(
    parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int TCK_DIV  = 2
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    labmininios_cpu_debug_host_if.slave bus,
    output logic [IR_WIDTH-1:0]      ir_in,
    output logic                     vs_uir,
    output logic                     vs_cdr,
    output logic                     vs_sdr,
    output logic                     vs_udr,
    output logic                     tck,
    output logic                     tdi,
    input  wire logic                tdo,
    output logic                     jtag_state_rti
);
    host_state_e         state_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                ir_only_q;
    logic                vs_uir_q;
    logic                vs_cdr_q;
    logic                vs_sdr_q;
    logic                vs_udr_q;
    logic                rsp_valid_q;
    logic                cmd_ready_q;
    logic                rti_q;

    logic                w_accept;
    logic                w_start;
    logic                w_sh_done;
    logic                w_sh_tck;
    logic                w_sh_tdi;
    logic [DR_WIDTH-1:0] w_capture;

    assign w_accept = cmd_ready_q && bus.cmd_valid;
    assign w_start  = (state_q == S_CDR);

    labmininios_cpu_debug_host_shifter #(
        .DR_WIDTH (DR_WIDTH),
        .TCK_DIV  (TCK_DIV)
    ) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (w_accept),
        .start_i   (w_start),
        .data_i    (bus.cmd_dr),
        .tdo_i     (tdo),
        .tck_o     (w_sh_tck),
        .tdi_o     (w_sh_tdi),
        .done_o    (w_sh_done),
        .capture_o (w_capture)
    );

    // Strobes are registered on the transition into their state so each
    // lines up exactly with the cycle the state is occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            ir_only_q   <= 1'b0;
            vs_uir_q    <= 1'b0;
            vs_cdr_q    <= 1'b0;
            vs_sdr_q    <= 1'b0;
            vs_udr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rti_q       <= 1'b1;
        end else begin
            vs_uir_q <= 1'b0;
            vs_cdr_q <= 1'b0;
            vs_udr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        state_q     <= S_UIR;
                        ir_q        <= bus.cmd_ir;
                        ir_only_q   <= bus.cmd_ir_only;
                        vs_uir_q    <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        rti_q       <= 1'b0;
                    end
                end
                S_UIR: begin
                    if (ir_only_q) begin
                        state_q     <= S_DONE;
                        rsp_valid_q <= 1'b1;
                        rti_q       <= 1'b1;
                    end else begin
                        state_q  <= S_CDR;
                        vs_cdr_q <= 1'b1;
                    end
                end
                S_CDR: begin
                    state_q  <= S_SDR;
                    vs_sdr_q <= 1'b1;
                end
                S_SDR: begin
                    if (w_sh_done) begin
                        state_q  <= S_UDR;
                        vs_sdr_q <= 1'b0;
                        vs_udr_q <= 1'b1;
                    end
                end
                S_UDR: begin
                    state_q     <= S_DONE;
                    rsp_valid_q <= 1'b1;
                    rti_q       <= 1'b1;
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    vs_sdr_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    rti_q       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dr    = rsp_valid_q ? w_capture : '0;

    assign ir_in          = ir_q;
    assign vs_uir         = vs_uir_q;
    assign vs_cdr         = vs_cdr_q;
    assign vs_sdr         = vs_sdr_q;
    assign vs_udr         = vs_udr_q;
    assign tck            = w_sh_tck;
    assign tdi            = w_sh_tdi;
    assign jtag_state_rti = rti_q;

endmodule
`default_nettype wire

// File: tb/tb_labmininios_cpu_debug_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_labmininios_cpu_debug_host
// Description : Self-checking bench for the debug host (DIV=2 and DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_labmininios_cpu_debug_host;
    localparam int IRW = 2;
    localparam int DRW = 38;
    localparam int DIV = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int tdo_mode;

    // ---------------- DUT A : default divider, tdo driven by mode ----------
    labmininios_cpu_debug_host_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) bus_a ();
    logic [IRW-1:0] a_ir_in;
    logic a_uir, a_cdr, a_sdr, a_udr, a_tck, a_tdi, a_tdo, a_rti;
    assign a_tdo = (tdo_mode == 0) ? a_tdi : (tdo_mode == 1) ? ~a_tdi : (tdo_mode == 2);

    labmininios_cpu_debug_host #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(DIV)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .ir_in(a_ir_in),
        .vs_uir(a_uir), .vs_cdr(a_cdr), .vs_sdr(a_sdr), .vs_udr(a_udr),
        .tck(a_tck), .tdi(a_tdi), .tdo(a_tdo), .jtag_state_rti(a_rti));

    // ---------------- DUT B : TCK_DIV=1, tdo tied high -----------------------
    labmininios_cpu_debug_host_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) bus_b ();
    logic [IRW-1:0] b_ir_in;
    logic b_uir, b_cdr, b_sdr, b_udr, b_tck, b_tdi, b_rti;

    labmininios_cpu_debug_host #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .ir_in(b_ir_in),
        .vs_uir(b_uir), .vs_cdr(b_cdr), .vs_sdr(b_sdr), .vs_udr(b_udr),
        .tck(b_tck), .tdi(b_tdi), .tdo(1'b1), .jtag_state_rti(b_rti));

    typedef struct {
        logic [IRW-1:0] ir;
        logic [DRW-1:0] dr;
        logic           io;
        int             mode;
        logic [DRW-1:0] exp_rsp;
        int             exp_lat;
    } vec_t;
    vec_t vecs[10];

    // Reference: what a complete request must return given how tdo relates to tdi.
    function automatic logic [DRW-1:0] model_rsp(input logic [DRW-1:0] dr, input logic io, input int mode);
        if (io) return '0;
        case (mode)
            0:       return dr;
            1:       return ~dr;
            2:       return '1;
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic io, input int div);
        return io ? 2 : 4 + DRW * div;
    endfunction

    function automatic logic [DRW-1:0] rand_dr();
        return DRW'({$urandom(), $urandom()});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int cyc, lat, uir_c, cdr_c, udr_c, sdr_n, tck_n;
        logic [DRW-1:0] tdi_w, rsp;
        logic [IRW-1:0] ir_at1;
        tdo_mode = v.mode;
        @(negedge clk);
        check({tag, "_ready_pre"}, 64'(bus_a.cmd_ready), 64'd1);
        bus_a.cmd_valid   = 1'b1;
        bus_a.cmd_ir      = v.ir;
        bus_a.cmd_dr      = v.dr;
        bus_a.cmd_ir_only = v.io;
        bus_a.rsp_ready   = 1'b1;
        cyc = 0; lat = -1; uir_c = -1; cdr_c = -1; udr_c = -1;
        sdr_n = 0; tck_n = 0; tdi_w = '0; rsp = '0; ir_at1 = '0;
        while (lat < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus_a.cmd_valid   = 1'b0;
                bus_a.cmd_dr      = rand_dr();
                bus_a.cmd_ir      = ~v.ir;
                bus_a.cmd_ir_only = ~v.io;
                ir_at1            = a_ir_in;
            end
            if (a_uir && uir_c < 0) uir_c = cyc;
            if (a_cdr && cdr_c < 0) cdr_c = cyc;
            if (a_udr && udr_c < 0) udr_c = cyc;
            if (a_sdr) sdr_n++;
            if (a_tck) begin
                if (tck_n < DRW) tdi_w[tck_n] = a_tdi;
                tck_n++;
            end
            if (bus_a.rsp_valid) begin
                lat = cyc;
                rsp = bus_a.rsp_dr;
            end
        end
        check({tag, "_uir_cyc"}, 64'(uir_c), 64'(1));
        check({tag, "_ir_in"},   64'(ir_at1), 64'(v.ir));
        check({tag, "_cdr_cyc"}, 64'(cdr_c), 64'(v.io ? -1 : 2));
        check({tag, "_udr_cyc"}, 64'(udr_c), 64'(v.io ? -1 : 3 + DRW * DIV));
        check({tag, "_sdr_len"}, 64'(sdr_n), 64'(v.io ? 0 : DRW * DIV));
        check({tag, "_tck_cnt"}, 64'(tck_n), 64'(v.io ? 0 : DRW));
        check({tag, "_tdi_seq"}, 64'(tdi_w), 64'(v.io ? '0 : v.dr));
        check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_rsp_dr"},  64'(rsp), 64'(v.exp_rsp));
        @(negedge clk);
        check({tag, "_ready_post"}, 64'({bus_a.cmd_ready, bus_a.rsp_valid, a_rti}), 64'(3'b101));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, run, maxrun, tck_n, lat;
        logic stable;
        logic [DRW-1:0] rsp0, d;
        logic [IRW-1:0] ir_used;

        reset_n = 1'b0;
        tdo_mode = 0;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_ir = '0; bus_a.cmd_dr = '0;
        bus_a.cmd_ir_only = 1'b0; bus_a.rsp_ready = 1'b0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_ir = '0; bus_b.cmd_dr = '0;
        bus_b.cmd_ir_only = 1'b0; bus_b.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_strobes", 64'({a_uir, a_cdr, a_sdr, a_udr, a_tck, a_tdi}), 64'(0));
        check("reset_ir_in",   64'(a_ir_in), 64'(0));
        check("reset_rsp",     64'({bus_a.rsp_valid, bus_a.rsp_dr}), 64'(0));
        check("reset_ready_rti", 64'({bus_a.cmd_ready, a_rti}), 64'(2'b11));
        reset_n = 1'b1;

        // Vector table: two fixed directed entries then random ones
        vecs[0].ir = 2'd2; vecs[0].dr = 38'h2A_5555_AAAA; vecs[0].io = 1'b0; vecs[0].mode = 0;
        vecs[1].ir = 2'd3; vecs[1].dr = rand_dr();        vecs[1].io = 1'b1; vecs[1].mode = 0;
        for (int i = 2; i < 10; i++) begin
            vecs[i].ir   = IRW'($urandom_range(0, 3));
            vecs[i].dr   = rand_dr();
            vecs[i].io   = ($urandom_range(0, 3) == 0);
            vecs[i].mode = $urandom_range(0, 3);
        end
        for (int i = 0; i < 10; i++) begin
            vecs[i].exp_rsp = model_rsp(vecs[i].dr, vecs[i].io, vecs[i].mode);
            vecs[i].exp_lat = model_lat(vecs[i].io, DIV);
        end
        for (int i = 0; i < 10; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // Response stall in DONE with a stray command pulse
        tdo_mode = 0;
        d = rand_dr();
        ir_used = 2'd1;
        @(negedge clk);
        bus_a.rsp_ready = 1'b0;
        bus_a.cmd_valid = 1'b1; bus_a.cmd_ir = ir_used; bus_a.cmd_dr = d; bus_a.cmd_ir_only = 1'b0;
        cyc = 0;
        while (!bus_a.rsp_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus_a.cmd_valid = 1'b0;
        end
        rsp0 = bus_a.rsp_dr;
        check("stall_rsp_dr", 64'(rsp0), 64'(d));
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus_a.cmd_valid = (k == 4);
            bus_a.cmd_ir = ~ir_used; bus_a.cmd_ir_only = 1'b1;
            @(negedge clk);
            if (!(bus_a.rsp_valid === 1'b1 && bus_a.rsp_dr === rsp0 &&
                  bus_a.cmd_ready === 1'b0 && a_ir_in === ir_used)) stable = 1'b0;
        end
        bus_a.cmd_valid = 1'b0;
        check("stall_hold", 64'(stable), 64'(1));
        bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 64'({bus_a.cmd_ready, bus_a.rsp_valid}), 64'(2'b10));

        // Reset during shift at bit 17
        @(negedge clk);
        bus_a.cmd_valid = 1'b1; bus_a.cmd_ir = 2'd2; bus_a.cmd_dr = rand_dr(); bus_a.cmd_ir_only = 1'b0;
        cyc = 0; tck_n = 0;
        while (tck_n < 17 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus_a.cmd_valid = 1'b0;
            if (a_tck) tck_n++;
        end
        check("midrst_reached_bit17", 64'(tck_n), 64'(17));
        check("midrst_in_sdr", 64'(a_sdr), 64'(1));
        reset_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({a_sdr, a_tck, a_tdi, a_ir_in, bus_a.rsp_valid}), 64'(0));
        check("midrst_ready", 64'({bus_a.cmd_ready, a_rti}), 64'(2'b11));
        @(negedge clk);
        reset_n = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_a.rsp_valid !== 1'b0) stable = 1'b0;
        end
        check("midrst_no_rsp", 64'(stable), 64'(1));
        run_cmd(vecs[0], "post_rst");

        // Back-to-back with rsp_ready held high
        @(negedge clk);
        bus_a.rsp_ready = 1'b1;
        bus_a.cmd_valid = 1'b1; bus_a.cmd_ir = 2'd1; bus_a.cmd_ir_only = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus_a.cmd_valid = 1'b0;
        end while (!bus_a.rsp_valid && cyc < 50);
        check("b2b_first_lat", 64'(cyc), 64'(2));
        bus_a.cmd_valid = 1'b1; bus_a.cmd_ir = 2'd2; bus_a.cmd_ir_only = 1'b1;
        @(negedge clk);
        check("b2b_idle_gap", 64'({bus_a.cmd_ready, a_ir_in}), 64'({1'b1, 2'd1}));
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        check("b2b_second_uir", 64'({a_uir, a_ir_in}), 64'({1'b1, 2'd2}));
        @(negedge clk);
        check("b2b_second_done", 64'({bus_a.rsp_valid, bus_a.rsp_dr}), 64'({1'b1, 38'd0}));
        @(negedge clk);

        // DUT B: divider of one, tdo tied high
        @(negedge clk);
        bus_b.rsp_ready = 1'b1;
        bus_b.cmd_valid = 1'b1; bus_b.cmd_ir = 2'd0; bus_b.cmd_dr = rand_dr(); bus_b.cmd_ir_only = 1'b0;
        cyc = 0; lat = -1; tck_n = 0; run = 0; maxrun = 0; rsp0 = '0;
        while (lat < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus_b.cmd_valid = 1'b0;
            if (b_tck) begin
                tck_n++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (bus_b.rsp_valid) begin
                lat = cyc;
                rsp0 = bus_b.rsp_dr;
            end
        end
        check("div1_tck_cnt", 64'(tck_n), 64'(DRW));
        check("div1_tck_run", 64'(maxrun), 64'(DRW));
        check("div1_latency", 64'(lat), 64'(model_lat(1'b0, 1)));
        check("div1_rsp_dr",  64'(rsp0), 64'(38'h3F_FFFF_FFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/labmininios_cpu_debug_host.md
# labmininios_cpu_debug_host

Clock-domain JTAG-side initiator for the Nios II debug slave. It drives the virtual-JTAG strobe set that the debug slave consumes (ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, tck, tdi) and collects tdo. A simple command/response handshake turns one request (IR value plus DR word) into one complete IR-update / capture / shift / update sequence. It replaces the tied-off simulation stubs for bench-driven and on-chip debug access.

## Interface
Parameters:
- IR_WIDTH, 2, width of virtual IR.
- DR_WIDTH, 38, shift-register length (matches jdo/sr).
- TCK_DIV, 2, clk cycles per shifted bit; legal range 1..16.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  block idle; a request is accepted on a cycle with cmd_valid && cmd_ready.
- cmd_ir  in  IR_WIDTH  IR value for the request.
- cmd_dr  in  DR_WIDTH  DR word to shift out, LSB first.
- cmd_ir_only  in  1  1 = IR update only, skip the DR phases.
- rsp_valid  out  1  response held until taken.
- rsp_ready  in  1  response consumer ready.
- rsp_dr  out  DR_WIDTH  captured tdo word; bit 0 = first bit shifted.
- ir_in  out  IR_WIDTH  current IR, held between commands.
- vs_uir, vs_cdr, vs_udr  out  1  one-cycle phase strobes.
- vs_sdr  out  1  high for the whole shift phase.
- tck  out  1  one-cycle shift strobe at the end of each bit period.
- tdi  out  1  serial data out.
- tdo  in  1  serial data in; sampled on the tck cycle.
- jtag_state_rti  out  1  high in IDLE and DONE.

## Operation
- State machine: IDLE, UIR, CDR, SDR, UDR, DONE.
  - IDLE -> UIR on accept.
  - UIR -> DONE if ir_only, else -> CDR.
  - CDR -> SDR.
  - SDR -> UDR after DR_WIDTH bits.
  - UDR -> DONE.
  - DONE -> IDLE on rsp_ready.
- Accept: latch cmd_ir into ir_in, cmd_dr into the shift register, cmd_ir_only into a flag. Clear the capture register.
- UIR: vs_uir=1. ir_in already shows the new value in this cycle.
- CDR: vs_cdr=1.
- SDR:
  - Bit counter runs 0..DR_WIDTH-1. Divider runs 0..TCK_DIV-1.
  - tdi = shift_reg[0], stable over the whole bit period.
  - tck=1 when divider = TCK_DIV-1. On that cycle:
    - capture <= {tdo, capture[DR_WIDTH-1:1]};
    - shift_reg >>= 1, filling with 0.
- UDR: vs_udr=1.
- DONE: rsp_valid=1, rsp_dr=capture. For ir_only, rsp_dr is all zeros.
- cmd_ready is 1 only in IDLE. There is no pipelining: one outstanding command.
- cmd_valid outside IDLE is ignored. Command inputs need not stay stable after accept.
- tdi=0 and tck=0 outside SDR.

## Timing
- Reset values: all strobes 0, tck=0, tdi=0, ir_in=0, rsp_valid=0, rsp_dr=0, cmd_ready=1, jtag_state_rti=1, state IDLE.
- Accept at edge 0 gives this cycle sequence:
  - cycle 1 UIR;
  - cycle 2 CDR;
  - cycles 3..2+DR_WIDTH*TCK_DIV SDR;
  - next cycle UDR;
  - next cycle DONE, rsp_valid rises.
- Full DR latency to rsp_valid = 4 + DR_WIDTH*TCK_DIV cycles (80 at defaults). ir_only latency = 2 cycles.
- rsp_valid && rsp_ready at an edge: the next cycle is IDLE with cmd_ready=1. A new command can be accepted that cycle, so the back-to-back gap is one cycle.
- rsp_ready high before DONE has no effect.
- Reset mid-operation: all outputs return to reset values asynchronously. The partially shifted word is discarded and no response is produced.
- Divider and bit counter are sized from clog2(TCK_DIV) and clog2(DR_WIDTH). Each wraps to 0 at its terminal count; there is no off-by-one at bit DR_WIDTH-1.

## Structure
- Shared package labmininios_cpu_debug_pkg holds:
  - state encoding localparams (IDLE..DONE);
  - the IR codes: 0 ocimem, 1 tracemem, 2 break, 3 trace control;
  - DR_WIDTH=38 default.
- One sub-module: labmininios_cpu_debug_host_shifter. It contains the divider, bit counter, shift and capture registers. Its interface is load, start, done, tck, tdi, tdo, and the data word.
- FSM and handshake logic stay in the top.

## Test plan
- Reset, then one full command: cmd_ir=2, cmd_dr=38'h2A_5555_AAAA, tdo looped to tdi.
  - vs_uir at cycle 1, vs_cdr at cycle 2, exactly 38 tck pulses, vs_udr at cycle 79, rsp_valid at cycle 80.
  - rsp_dr = 38'h2A_5555_AAAA.
- cmd_ir_only=1, cmd_ir=3 -> ir_in=3 from cycle 1; no vs_cdr, vs_sdr, tck or vs_udr; rsp_valid at cycle 2 with rsp_dr=0.
- tdo tied 1 with TCK_DIV=1 -> 38 consecutive tck cycles; rsp_dr=38'h3F_FFFF_FFFF; latency 42.
- rsp_ready held low for 10 cycles in DONE -> rsp_valid and rsp_dr stable; cmd_ready=0; a cmd_valid pulse is ignored. Release -> cmd_ready=1 the next cycle.
- reset_n pulsed low at bit 17 of SDR -> vs_sdr=0, tck=0, ir_in=0 immediately, no rsp_valid. A following command completes normally.
- Back-to-back commands with rsp_ready tied 1 -> second accept exactly one cycle after DONE; ir_in updates in that accept cycle's successor.
